// File: rtl/bus_responder_6502.sv
// 6502C bus-side scratch RAM responder: address-window decode, RDY wait states, byte RAM.
// Optional write protection of the low ROM_WORDS offsets is enabled with `define WRITE_PROTECT_EN.
module bus_responder_6502 #(
    parameter logic [15:0] BASE_ADDR   = 16'hC000,
    parameter int          ADDR_BITS   = 6,
    parameter int          WAIT_STATES = 2,
    parameter int          ROM_WORDS   = 16
) (
    input  logic        phi2,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic        R_W,
    input  logic        valid,
    input  logic [7:0]  dataIn,
    output logic [7:0]  dataOut,
    output logic        data_oe,
    output logic        RDY,
    output logic        wp_err
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [3:0] WS = WAIT_STATES[3:0];

    state_t               state;
    logic [3:0]           cnt;
    logic [ADDR_BITS-1:0] lat_off;
    logic                 lat_rw;
    logic [7:0]           lat_data;
    logic [7:0]           mem [2**ADDR_BITS];

    logic                 hit;
    logic [ADDR_BITS-1:0] off;
    logic                 commit;
    logic [ADDR_BITS-1:0] acc_off;
    logic                 acc_rw;
    logic [7:0]           acc_data;
    logic                 prot;

    assign hit = valid && (addr[15:ADDR_BITS] == BASE_ADDR[15:ADDR_BITS]);
    assign off = addr[ADDR_BITS-1:0];

    // With zero wait states the access completes straight from IDLE using the live bus,
    // otherwise from the values latched when the cycle was accepted.
    always_comb begin
        commit   = 1'b0;
        acc_off  = lat_off;
        acc_rw   = lat_rw;
        acc_data = lat_data;
        if (state == IDLE) begin
            commit   = hit && (WS == 4'd0);
            acc_off  = off;
            acc_rw   = R_W;
            acc_data = dataIn;
        end else if (state == WAIT) begin
            commit = (cnt == WS);
        end
    end

`ifdef WRITE_PROTECT_EN
    localparam logic [ADDR_BITS:0] ROM_LIM = ROM_WORDS[ADDR_BITS:0];

    assign prot = !acc_rw && ({1'b0, acc_off} < ROM_LIM);

    always_ff @(posedge phi2) begin
        if (rst) wp_err <= 1'b0;
        else     wp_err <= commit && prot;
    end
`else
    assign prot   = 1'b0;
    assign wp_err = 1'b0;
`endif

    // RAM is deliberately not reset; a reset edge never commits a write.
    always_ff @(posedge phi2) begin
        if (!rst && commit && !acc_rw && !prot)
            mem[acc_off] <= acc_data;
    end

    always_ff @(posedge phi2) begin
        if (rst) begin
            state    <= IDLE;
            RDY      <= 1'b1;
            data_oe  <= 1'b0;
            dataOut  <= 8'h00;
            cnt      <= 4'd0;
            lat_off  <= '0;
            lat_rw   <= 1'b1;
            lat_data <= 8'h00;
        end else begin
            data_oe <= 1'b0;
            case (state)
                IDLE: begin
                    if (hit) begin
                        lat_off  <= off;
                        lat_rw   <= R_W;
                        lat_data <= dataIn;
                        if (WS == 4'd0) begin
                            state <= DONE;
                        end else begin
                            state <= WAIT;
                            RDY   <= 1'b0;
                            cnt   <= 4'd1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == WS) begin
                        state <= DONE;
                        RDY   <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (commit && acc_rw) begin
                dataOut <= mem[acc_off];
                data_oe <= 1'b1;
            end
        end
    end
endmodule
